// File: rtl/dmem_dump_reader_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_dump_reader_if
//
// Bundles the two buses of the data-memory dump reader:
//   - data-memory read port : o_Addr, o_Re, o_We, o_size_control (to memory),
//                             i_Data (from memory)
//   - byte stream to the debug UART transmitter : o_tx_data, o_tx_valid
//                             (to transmitter), i_tx_ready (from transmitter)
// Signal names keep the memory/transmitter naming so that the reader side
// (master) reads exactly like the port list it replaces.
//
// Modports:
//   master : the dump reader (drives address, strobes and byte stream)
//   slave  : memory + transmitter side (drives read data and ready)
// -----------------------------------------------------------------------------
interface dmem_dump_reader_if #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
);
    logic [ADDR_LENGTH-1:0] o_Addr;
    logic                   o_Re;
    logic                   o_We;
    logic [4:0]             o_size_control;
    logic [DATA_LENGTH-1:0] i_Data;
    logic [7:0]             o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready;

    modport master (
        output o_Addr, o_Re, o_We, o_size_control, o_tx_data, o_tx_valid,
        input  i_Data, i_tx_ready
    );

    modport slave (
        input  o_Addr, o_Re, o_We, o_size_control, o_tx_data, o_tx_valid,
        output i_Data, i_tx_ready
    );
endinterface

// File: rtl/dmem_dump_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_dump_reader
//
// Debug-side reader for the data memory. On a start pulse it walks every
// data-memory word in ascending address order, issuing full-word unsigned
// loads, captures each word and streams it MSB-first as bytes over a
// valid/ready interface to the debug UART transmitter.
//
// Ports:
//   i_clk    : clock, all state changes on the rising edge
//   i_rst    : asynchronous active-low reset
//   i_start  : start request, only honoured in IDLE
//   bus      : dmem_dump_reader_if.master (memory read port + tx byte stream)
//   o_busy   : high in every state except IDLE
//   o_done   : one-cycle pulse after the last byte has been accepted
//
// Per word: REQ (address presented), CAPT (address held, data latched at the
// end of the cycle), then one SEND cycle per byte handshake. Holding the
// address for two cycles lets both combinational and clocked-read memories
// deliver valid data at the CAPT edge.
// -----------------------------------------------------------------------------
module dmem_dump_reader #(
    parameter int         MEM_SIZE       = 5,
    parameter int         ADDR_LENGTH    = 32,
    parameter int         DATA_LENGTH    = 32,
    parameter int         ADDR_STRIDE    = 1,
    parameter logic [4:0] SIZE_WORD_LOAD = 5'b11000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    dmem_dump_reader_if.master    bus,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int N_WORDS = 2 ** MEM_SIZE;
    localparam int BYTES   = DATA_LENGTH / 8;
    localparam int BCNT_W  = $clog2(BYTES) + 1;

    localparam logic [MEM_SIZE:0] LAST_INDEX = (MEM_SIZE + 1)'(N_WORDS - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        SEND,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;

    // One extra bit so the index never wraps inside a dump.
    logic [MEM_SIZE:0]      index;
    logic [BCNT_W-1:0]      byte_cnt;
    logic [DATA_LENGTH-1:0] shreg;

    // Datapath strobes decoded by the FSM.
    logic                   idx_clr;
    logic                   idx_inc;
    logic                   load_word;
    logic                   shift_byte;

    logic [ADDR_LENGTH-1:0] word_addr;

    assign word_addr = ADDR_LENGTH'(index) * ADDR_LENGTH'(ADDR_STRIDE);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the shift register is a plain register, not a memory array, so it
    // is reset; that keeps the byte output at a known 0 after reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            index    <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            state <= state_next;

            if (idx_clr) begin
                index <= '0;
            end else if (idx_inc) begin
                index <= index + 1'b1;
            end

            if (load_word) begin
                shreg    <= bus.i_Data;
                byte_cnt <= '0;
            end else if (shift_byte) begin
                shreg    <= shreg << 8;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next         = state;
        idx_clr            = 1'b0;
        idx_inc            = 1'b0;
        load_word          = 1'b0;
        shift_byte         = 1'b0;

        bus.o_Addr         = '0;
        bus.o_Re           = 1'b0;
        bus.o_We           = 1'b0;
        bus.o_size_control = '0;
        bus.o_tx_data      = '0;
        bus.o_tx_valid     = 1'b0;
        o_busy             = 1'b1;
        o_done             = 1'b0;

        unique case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    idx_clr    = 1'b1;
                    state_next = REQ;
                end
            end

            REQ: begin
                bus.o_Re           = 1'b1;
                bus.o_Addr         = word_addr;
                bus.o_size_control = SIZE_WORD_LOAD;
                state_next         = CAPT;
            end

            CAPT: begin
                // Address held a second cycle; data is taken at this edge.
                bus.o_Re           = 1'b1;
                bus.o_Addr         = word_addr;
                bus.o_size_control = SIZE_WORD_LOAD;
                load_word          = 1'b1;
                state_next         = SEND;
            end

            SEND: begin
                bus.o_tx_valid = 1'b1;
                bus.o_tx_data  = shreg[DATA_LENGTH-1 -: 8];
                if (bus.i_tx_ready) begin
                    shift_byte = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        if (index == LAST_INDEX) begin
                            state_next = DONE;
                        end else begin
                            idx_inc    = 1'b1;
                            state_next = REQ;
                        end
                    end
                end
            end

            DONE: begin
                // A start arriving here is dropped: DONE always returns to IDLE.
                o_done     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_dump_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_dmem_dump_reader
//
// Directed bench for dmem_dump_reader with a behavioural data memory
// (combinational read) and a scoreboard: expected addresses and bytes are
// queued from the memory contents when a dump is started, and popped by a
// negedge monitor as the DUT presents addresses and completes byte handshakes.
// -----------------------------------------------------------------------------
module tb_dmem_dump_reader;

    localparam int         MEM_SIZE       = 5;
    localparam int         ADDR_LENGTH    = 32;
    localparam int         DATA_LENGTH    = 32;
    localparam int         N_WORDS        = 32;
    localparam int         BYTES          = 4;
    localparam logic [4:0] SIZE_WORD_LOAD = 5'b11000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic o_busy;
    logic o_done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int e0          = 0;
    int bytes_seen  = 0;
    bit mon_en      = 1'b0;
    bit re_prev     = 1'b0;

    logic [31:0] mem [N_WORDS];
    logic [7:0]  exp_q  [$];
    logic [31:0] addr_q [$];
    logic [7:0]  mon_e;
    logic [31:0] mon_a;

    dmem_dump_reader_if #(
        .ADDR_LENGTH(ADDR_LENGTH),
        .DATA_LENGTH(DATA_LENGTH)
    ) bus ();

    dmem_dump_reader #(
        .MEM_SIZE      (MEM_SIZE),
        .ADDR_LENGTH   (ADDR_LENGTH),
        .DATA_LENGTH   (DATA_LENGTH),
        .ADDR_STRIDE   (1),
        .SIZE_WORD_LOAD(SIZE_WORD_LOAD)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_start(start),
        .bus    (bus),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational-read data memory.
    assign bus.i_Data = bus.o_Re ? mem[bus.o_Addr[MEM_SIZE-1:0]] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!mon_en) begin
            re_prev    = 1'b0;
            bytes_seen = 0;
        end else begin
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, mon_e});
                    bytes_seen++;
                end
            end
            if (!bus.o_tx_valid) check("tx_data_idle", {24'd0, bus.o_tx_data}, 32'd0);
            if (bus.o_Re && !re_prev) begin
                if (addr_q.size() == 0) begin
                    check("extra_addr", 32'd1, 32'd0);
                end else begin
                    mon_a = addr_q.pop_front();
                    check("addr", bus.o_Addr, mon_a);
                end
            end
            if (bus.o_Re) begin
                check("size_ctl", {27'd0, bus.o_size_control}, {27'd0, SIZE_WORD_LOAD});
            end else begin
                check("addr_idle", bus.o_Addr, 32'd0);
                check("size_idle", {27'd0, bus.o_size_control}, 32'd0);
            end
            check("we", {31'd0, bus.o_We}, 32'd0);
            re_prev = bus.o_Re;
        end
    end

    task automatic push_expected();
        for (int w = 0; w < N_WORDS; w++) begin
            addr_q.push_back(32'(w));
            for (int b = 0; b < BYTES; b++) begin
                exp_q.push_back(mem[w][31 - 8*b -: 8]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, o_busy},         32'd0);
        check({tag, "_done"},  {31'd0, o_done},         32'd0);
        check({tag, "_valid"}, {31'd0, bus.o_tx_valid}, 32'd0);
        check({tag, "_txd"},   {24'd0, bus.o_tx_data},  32'd0);
        check({tag, "_re"},    {31'd0, bus.o_Re},       32'd0);
        check({tag, "_we"},    {31'd0, bus.o_We},       32'd0);
        check({tag, "_addr"},  bus.o_Addr,              32'd0);
    endtask

    // Starts a dump and runs it cycle by cycle. n is the cycle number after the
    // start-sampling edge E0 (REQ of word 0 is cycle 1).
    task automatic run_dump(input int start_a, input int start_b, input int stall_at,
                            input int abort_at, input bit rnd, input int exp_done);
        int n;
        int b0;
        bit found;
        found = 1'b0;
        b0    = bytes_seen;
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        e0 = cyc;
        for (n = 1; n <= 3000; n++) begin
            if (rnd) bus.i_tx_ready = ($urandom_range(0, 99) >= 30);
            if (stall_at > 0 && n == stall_at)     bus.i_tx_ready = 1'b0;
            if (stall_at > 0 && n == stall_at + 5) bus.i_tx_ready = 1'b1;
            start = (n == start_a || n == start_b);
            if (stall_at > 0 && n >= stall_at && n < stall_at + 5) begin
                check("stall_valid", {31'd0, bus.o_tx_valid}, 32'd1);
                check("stall_data",  {24'd0, bus.o_tx_data},  32'h0000_00FF);
            end
            if (n == abort_at) begin
                check("pre_abort_valid", {31'd0, bus.o_tx_valid}, 32'd1);
                mon_en = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                break;
            end
            if (o_done) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (abort_at == 0) begin
            check("done_seen", {31'd0, found}, 32'd1);
            if (found && exp_done > 0) check("done_cycle", 32'(n), 32'(exp_done));
            check("bytes_left", 32'(exp_q.size()), 32'd0);
            check("addrs_left", 32'(addr_q.size()), 32'd0);
            check("byte_count", 32'(bytes_seen - b0), 32'(N_WORDS * BYTES));
        end
    endtask

    initial begin
        bus.i_tx_ready = 1'b0;
        for (int i = 0; i < N_WORDS; i++) mem[i] = 32'd0;
        mem[0] = 32'd1;
        mem[1] = 32'd22;
        mem[2] = 32'd33;
        mem[3] = 32'hFF00_FFFF;
        mem[4] = 32'd5;

        // Reset held from time 0: outputs forced to 0.
        #2;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        // No start: outputs stay quiet.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_reset_busy",  {31'd0, o_busy},         32'd0);
            check("post_reset_valid", {31'd0, bus.o_tx_valid}, 32'd0);
        end

        // Full dump, ready held high, a start while busy and a start in DONE.
        mon_en         = 1'b1;
        bus.i_tx_ready = 1'b1;
        run_dump(50, 193, 0, 0, 1'b0, 193);
        @(posedge clk); #1 start = 1'b0;
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
        check("start_in_done_dropped", {31'd0, o_busy}, 32'd0);
        @(posedge clk); #1;
        check("still_idle", {31'd0, o_busy}, 32'd0);

        // Second dump with 5 stall cycles on byte 2 of word 3.
        run_dump(0, 0, 23, 0, 1'b0, 198);
        @(posedge clk); #1;
        check("idle_after_stall_dump", {31'd0, o_busy}, 32'd0);

        // Reset while sending word 10.
        run_dump(0, 0, 0, 64, 1'b0, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("after_abort_busy", {31'd0, o_busy}, 32'd0);
        end

        // Random contents, random stalls (30%); restarts at address 0.
        for (int i = 0; i < N_WORDS; i++) mem[i] = $urandom();
        mon_en = 1'b1;
        run_dump(0, 0, 0, 0, 1'b1, 0);

        bus.i_tx_ready = 1'b1;
        @(posedge clk); #1;
        check("final_idle", {31'd0, o_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Debug-side reader for the data memory: on a start pulse it walks every data-memory word in ascending address order and issues full-word unsigned loads. It captures each word and streams it out MSB-first as bytes over a valid/ready byte interface to the debug UART transmitter. It sits between `data_memory` and the debug unit's transmit path, and is the read-out counterpart of the store path that fills memory during a program run.

## Interface
- `MEM_SIZE`, 5, log2 of the number of words dumped; N_WORDS = 2**MEM_SIZE.
- `ADDR_LENGTH`, 32, width of the memory address bus.
- `DATA_LENGTH`, 32, width of the memory data bus; must be a multiple of 8. BYTES = DATA_LENGTH/8.
- `ADDR_STRIDE`, 1, address increment between consecutive words.
- `SIZE_WORD_LOAD`, 5'b11000, `size_control` code for a full-word unsigned load.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_Data`  in  DATA_LENGTH  read data from the memory's `o_Data`.
- `o_Addr`  out  ADDR_LENGTH  memory address.
- `o_Re`  out  1  memory read enable.
- `o_We`  out  1  memory write enable; constant 0.
- `o_size_control`  out  5  memory access size; SIZE_WORD_LOAD while `o_Re`=1, else 0.
- `o_tx_data`  out  8  byte to transmitter.
- `o_tx_valid`  out  1  byte valid.
- `i_tx_ready`  in  1  transmitter accepts the byte.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when the last byte has been accepted.

## Operation
- **State machine: IDLE, REQ, CAPT, SEND, DONE.**
- **IDLE:** all outputs 0.
  - `i_start`=1 → REQ, with word index = 0.
- **REQ:**
  - `o_Re`=1; `o_Addr` = index*ADDR_STRIDE (truncated to ADDR_LENGTH).
  - Unconditionally → CAPT.
- **CAPT:**
  - `o_Re` and `o_Addr` are held.
  - `i_Data` is latched into the shift register at the end of the cycle, and byte count is set to 0.
  - → SEND.
  - The data is valid one cycle after the address is presented, so both combinational and clocked-read memories are covered.
- **SEND:**
  - `o_tx_valid`=1; `o_tx_data` = shift register [DATA_LENGTH-1 -: 8].
  - On `o_tx_valid`&&`i_tx_ready`: shift left by 8 and increment the byte count.
  - On the handshake of byte BYTES-1:
    - if index == N_WORDS-1 → DONE;
    - else index+1 → REQ.
- **DONE:** `o_done`=1 for one cycle → IDLE.
- **Start handling:** `i_start` is ignored outside IDLE. A start in the DONE cycle is dropped.
- **Index width:** the index counter is MEM_SIZE+1 bits and never wraps during a dump. Each dump restarts at address 0.
- **Output stability:** `o_Addr`/`o_size_control` are 0 outside REQ/CAPT. `o_tx_data` is 0 outside SEND.
- **Write enable:** `o_We` is never asserted.

## Timing
- **Reset:** `i_rst` low forces IDLE immediately (asynchronously). Index, byte count, shift register and all outputs go to 0. This applies mid-operation too: an in-flight byte is abandoned (`o_tx_valid` drops without handshake).
- **Start latency:** start is sampled on edge E0; REQ occupies the cycle after E0.
- **Per word:** 2 cycles (REQ, CAPT) + BYTES handshake cycles. With `i_tx_ready` held 1, that is 6 cycles per word at 32 bits.
- **Full dump:** with `i_tx_ready`=1, `o_done` is high in cycle 6*N_WORDS+1 after E0 (193 with defaults).
- **Backpressure:** while `o_tx_valid`=1 and `i_tx_ready`=0, `o_tx_data` and `o_tx_valid` hold stable. No byte is dropped or repeated.
- **`i_Data` usage:** ignored except at the CAPT edge.

## Test plan
- **Reset:** assert `i_rst`=0 mid-cycle → all outputs 0 immediately. Release, and with no `i_start` outputs stay 0.
- **Full dump:**
  - Stimulus: preload memory words 0..4 = 1, 22, 33, 0xFF00FFFF, 5 (rest 0); `i_tx_ready`=1; pulse `i_start`.
  - Byte stream begins 00 00 00 01 00 00 00 16 00 00 00 21 FF 00 FF FF 00 00 00 05, with 128 bytes total.
  - `o_Addr` steps 0..31, `o_We` never 1, `o_done` pulses in cycle 193.
- **Backpressure:** drop `i_tx_ready` for 5 cycles while byte 2 of word 3 (0xFF) is offered → `o_tx_data`=0xFF and `o_tx_valid`=1 held throughout. The stream is unchanged, and `o_done` is delayed by exactly 5 cycles.
- **Start while busy:** pulse `i_start` while busy → ignored, and the stream is identical to the full-dump scenario. A new start after `o_done` → second dump restarts at address 0 with an identical stream.
- **Reset mid-SEND:** reset asserted during word 10 → outputs 0 at once. Next start dumps from address 0.
- **Random stall:** random `i_tx_ready` with 30% stall probability → received bytes match a scoreboard of memory contents, MSB-first, with no gaps or duplicates.
